// File: rtl/dac_serializer_pkg.sv
// Shared constants for the DAC serializer: FSM encoding and serial frame layout.
package dac_serializer_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StGap   = 2'd3;

  localparam int unsigned FrameLen = 16;

  // Leading zero control bits that pad the DAC code up to a full frame.
  function automatic int unsigned ctrl_bits(input int unsigned dac_bits);
    return FrameLen - dac_bits;
  endfunction

endpackage

// File: rtl/dac_serializer_sat_offset.sv
// Filter sample to DAC code: arithmetic shift, clamp to the signed DAC range,
// then flip the sign bit to get offset binary.
module sat_offset #(
  parameter int unsigned Width   = 25,
  parameter int unsigned DacBits = 12,
  parameter int unsigned Shift   = 10
) (
  input  logic [Width-1:0]   din,
  output logic [DacBits-1:0] code
);

  localparam logic signed [Width-1:0] VMax = Width'((1 << (DacBits - 1)) - 1);
  localparam logic signed [Width-1:0] VMin = ~VMax;

  logic signed [Width-1:0] v;

  always_comb begin
    v = $signed(din) >>> Shift;
    if (v > VMax) begin
      code = {DacBits{1'b1}};
    end else if (v < VMin) begin
      code = '0;
    end else begin
      code = {~v[DacBits-1], v[DacBits-2:0]};
    end
  end

endmodule

// File: rtl/dac_serializer.sv
// Serializes one filter sample per enable strobe into a 16-bit SPI-style DAC frame.
module dac_serializer
  import dac_serializer_pkg::*;
#(
  parameter int unsigned Width   = 25,
  parameter int unsigned DacBits = 12,
  parameter int unsigned Shift   = 10,
  parameter int unsigned ClkDiv  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [Width-1:0] datoIn,
  output logic             sclk,
  output logic             sync_n,
  output logic             dout,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int unsigned     CtrlBits = ctrl_bits(DacBits);
  localparam int unsigned     DivW     = $clog2(2 * ClkDiv);
  localparam logic [DivW-1:0] DivLast  = DivW'(2 * ClkDiv - 1);
  localparam logic [DivW-1:0] DivHigh  = DivW'(ClkDiv);
  localparam logic [DivW-1:0] DivDone  = DivW'(2 * ClkDiv - 2);
  localparam logic [3:0]      BitFirst = 4'(FrameLen - 1);

  logic [1:0]          state_q, state_d;
  logic [Width-1:0]    sample_q, sample_d;
  logic [FrameLen-1:0] shreg_q, shreg_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [DivW-1:0]     div_cnt_q, div_cnt_d;
  logic                sclk_q, sclk_d;
  logic                sync_n_q, sync_n_d;
  logic                dout_q, dout_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;

  logic [DacBits-1:0]  code;
  logic [FrameLen-1:0] frame;
  logic [DivW-1:0]     div_nxt;

  sat_offset #(
    .Width  (Width),
    .DacBits(DacBits),
    .Shift  (Shift)
  ) u_sat_offset (
    .din (sample_q),
    .code(code)
  );

  assign frame   = {{CtrlBits{1'b0}}, code};
  assign div_nxt = div_cnt_q + DivW'(1);

  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    sclk_d    = sclk_q;
    sync_n_d  = sync_n_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    // Any strobe outside IDLE is dropped; remember that it happened.
    overrun_d = overrun_q | (enable & (state_q != StIdle));

    case (state_q)
      StIdle: begin
        sclk_d   = 1'b1;
        sync_n_d = 1'b1;
        dout_d   = 1'b0;
        if (enable) begin
          sample_d = datoIn;
          state_d  = StLoad;
        end
      end

      StLoad: begin
        shreg_d   = frame;
        dout_d    = frame[FrameLen-1];
        bit_cnt_d = BitFirst;
        div_cnt_d = '0;
        sclk_d    = 1'b1;
        sync_n_d  = 1'b0;
        state_d   = StShift;
      end

      StShift: begin
        if (div_cnt_q == DivLast) begin
          div_cnt_d = '0;
          sclk_d    = 1'b1;
          if (bit_cnt_q == 4'd0) begin
            sync_n_d = 1'b1;
            dout_d   = 1'b0;
            state_d  = StGap;
          end else begin
            // shreg_q[MSB] is the bit on the wire; the next one moves up.
            bit_cnt_d = bit_cnt_q - 4'd1;
            shreg_d   = shreg_q << 1;
            dout_d    = shreg_q[FrameLen-2];
          end
        end else begin
          div_cnt_d = div_nxt;
          sclk_d    = div_nxt < DivHigh;
        end
      end

      StGap: begin
        sclk_d   = 1'b1;
        sync_n_d = 1'b1;
        dout_d   = 1'b0;
        done_d   = (div_cnt_q == DivDone);
        if (div_cnt_q == DivLast) begin
          div_cnt_d = '0;
          state_d   = StIdle;
        end else begin
          div_cnt_d = div_nxt;
        end
      end

      default: begin
        sclk_d    = 1'b1;
        sync_n_d  = 1'b1;
        dout_d    = 1'b0;
        div_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      sample_q  <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sclk_q    <= 1'b1;
      sync_n_q  <= 1'b1;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
      sync_n_q  <= sync_n_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign sclk    = sclk_q;
  assign sync_n  = sync_n_q;
  assign dout    = dout_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_dac_serializer.sv
// Bench for dac_serializer: ClkDiv=2 and ClkDiv=1 instances against an arithmetic frame model.
module tb_dac_serializer;

  localparam int Shift   = 10;
  localparam int DacBits = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        en0, en1;
  logic [24:0] d0, d1;
  logic        sclk0, sync_n0, dout0, busy0, done0, overrun0;
  logic        sclk1, sync_n1, dout1, busy1, done1, overrun1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] cap0 = '0, cap1 = '0;
  int          nb0 = 0, nb1 = 0;

  always #5 clk = ~clk;

  dac_serializer #(.Width(25), .DacBits(12), .Shift(10), .ClkDiv(2)) dut (
    .clk(clk), .reset(reset), .enable(en0), .datoIn(d0),
    .sclk(sclk0), .sync_n(sync_n0), .dout(dout0),
    .busy(busy0), .done(done0), .overrun(overrun0)
  );

  dac_serializer #(.Width(25), .DacBits(12), .Shift(10), .ClkDiv(1)) dut1 (
    .clk(clk), .reset(reset), .enable(en1), .datoIn(d1),
    .sclk(sclk1), .sync_n(sync_n1), .dout(dout1),
    .busy(busy1), .done(done1), .overrun(overrun1)
  );

  // DAC-side receivers: latch dout on every falling sclk inside a frame.
  always @(negedge sclk0) if (sync_n0 === 1'b0) begin cap0 = {cap0[14:0], dout0}; nb0++; end
  always @(negedge sclk1) if (sync_n1 === 1'b0) begin cap1 = {cap1[14:0], dout1}; nb1++; end

  function automatic logic [15:0] model_frame(input logic [24:0] d);
    longint v, lim, div;
    div = longint'(1) << Shift;
    lim = longint'(1) << (DacBits - 1);
    v   = longint'($signed(d));
    if (v < 0) v = -((-v + div - 1) / div);
    else       v = v / div;
    if (v > lim - 1) v = lim - 1;
    if (v < -lim)    v = -lim;
    return 16'(v + lim);
  endfunction

  task automatic drive(input int sel, input logic en, input logic [24:0] d);
    if (sel == 1) begin en1 = en; d1 = d; end
    else          begin en0 = en; d0 = d; end
  endtask

  // Caller is at a negedge; enable goes in this cycle. Returns at the negedge of the done cycle.
  task automatic run_frame(input int sel, input logic [24:0] d, input string name,
                           input int inj_k, input logic [24:0] inj_d);
    int c, last, done_k, errs, nstart, idx, ncap;
    logic [15:0] exp, cap;
    logic s_sclk, s_sync, s_dout, s_busy, s_done;
    logic e_sclk, e_sync, e_dout;
    bit   in_shift;
    c      = (sel == 1) ? 1 : 2;
    last   = 1 + 34 * c;
    exp    = model_frame(d);
    nstart = (sel == 1) ? nb1 : nb0;
    done_k = -1;
    errs   = 0;
    drive(sel, 1'b1, d);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == inj_k)           drive(sel, 1'b1, inj_d);
      else                      drive(sel, 1'b0, 25'($urandom));
      s_sclk = (sel == 1) ? sclk1   : sclk0;
      s_sync = (sel == 1) ? sync_n1 : sync_n0;
      s_dout = (sel == 1) ? dout1   : dout0;
      s_busy = (sel == 1) ? busy1   : busy0;
      s_done = (sel == 1) ? done1   : done0;
      in_shift = (k >= 2) && (k <= 1 + 32 * c);
      idx    = (k - 2) / (2 * c);
      e_sync = !in_shift;
      e_sclk = in_shift ? (((k - 2) % (2 * c)) < c) : 1'b1;
      e_dout = in_shift ? exp[15 - idx] : 1'b0;
      if (s_sclk !== e_sclk || s_sync !== e_sync || s_dout !== e_dout || s_busy !== 1'b1
          || s_done !== (k == last)) errs++;
      if (s_done === 1'b1 && done_k < 0) done_k = k;
    end
    drive(sel, 1'b0, 25'($urandom));
    cap  = (sel == 1) ? cap1 : cap0;
    ncap = ((sel == 1) ? nb1 : nb0) - nstart;
    n_cmp++;
    if (errs !== 0) begin
      n_fail++;
      $display("FAIL %s waveform: %0d bad cycles, required 0", name, errs);
    end
    n_cmp++;
    if (done_k !== last) begin
      n_fail++;
      $display("FAIL %s latency: done in cycle %0d, required %0d", name, done_k, last);
    end
    n_cmp++;
    if (ncap !== 16 || cap !== exp) begin
      n_fail++;
      $display("FAIL %s frame: got %h (%0d bits), required %h (16 bits)", name, cap, ncap, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 1'b1, 25'($urandom));
    drive(1, 1'b1, 25'($urandom));
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sclk0, sync_n0, dout0, busy0, done0, overrun0} !== 6'b110000) begin
      n_fail++;
      $display("FAIL reset_outs0: got %b, required 110000",
               {sclk0, sync_n0, dout0, busy0, done0, overrun0});
    end
    n_cmp++;
    if ({sclk1, sync_n1, dout1, busy1, done1, overrun1} !== 6'b110000) begin
      n_fail++;
      $display("FAIL reset_outs1: got %b, required 110000",
               {sclk1, sync_n1, dout1, busy1, done1, overrun1});
    end
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy0, sync_n0} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_dominates: busy,sync_n got %b, required 01", {busy0, sync_n0});
    end
  endtask

  task automatic test_directed(input int sel);
    logic [24:0] vals [5];
    vals = '{25'h0000000, 25'h0100000, 25'h0FFFFFF, 25'h1000000, 25'h1FFFFFF};
    @(negedge clk);
    foreach (vals[i]) begin
      run_frame(sel, vals[i], $sformatf("directed%0d_%h", sel, vals[i]), 0, '0);
      @(negedge clk);
    end
    n_cmp++;
    if (((sel == 1) ? overrun1 : overrun0) !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_overrun%0d: got 1, required 0", sel);
    end
  endtask

  task automatic test_random(input int sel, input int n);
    logic [24:0] d;
    int r;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        d = 25'($urandom);
      end else begin
        r = int'($urandom_range(0, 4200)) - 2100;
        d = 25'(r * 1024 + int'($urandom_range(0, 1023)));
      end
      run_frame(sel, d, $sformatf("random%0d_%h", sel, d), 0, '0);
      @(negedge clk);
    end
  endtask

  task automatic test_done_collision();
    int busy_seen;
    run_frame(0, 25'h0012345, "collision_first", 0, '0);
    n_cmp++;
    if (overrun0 !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_pre_overrun: got %b, required 0", overrun0);
    end
    drive(0, 1'b1, 25'h0F00000);
    @(negedge clk);
    drive(0, 1'b0, '0);
    busy_seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy0 !== 1'b0) busy_seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (overrun0 !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_overrun: got %b, required 1", overrun0);
    end
    n_cmp++;
    if (busy_seen !== 0) begin
      n_fail++;
      $display("FAIL collision_ignored: busy in %0d cycles, required 0", busy_seen);
    end
    run_frame(0, 25'h1F80000, "after_collision", 0, '0);
    @(negedge clk);
  endtask

  task automatic test_overrun();
    pulse_reset();
    run_frame(0, 25'h0080400, "overrun_frame", 10, 25'h1000000);
    n_cmp++;
    if (overrun0 !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got %b, required 1", overrun0);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (overrun0 !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: got %b, required 1", overrun0);
    end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    drive(0, 1'b1, 25'h0155555);
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      drive(0, 1'b0, 25'($urandom));
    end
    // Cycle 42 is the start of frame bit 5.
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({sclk0, sync_n0, busy0, overrun0, done0} !== 5'b11000) begin
      n_fail++;
      $display("FAIL reset_mid: sclk,sync_n,busy,overrun,done got %b, required 11000",
               {sclk0, sync_n0, busy0, overrun0, done0});
    end
    reset = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done0 !== 1'b0 || busy0 !== 1'b0) done_seen++;
    end
    n_cmp++;
    if (done_seen !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: activity in %0d cycles, required 0", done_seen);
    end
  endtask

  initial begin
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    test_reset();
    test_directed(0);
    test_random(0, 16);
    test_done_collision();
    test_overrun();
    test_reset_mid();
    test_directed(1);
    test_random(1, 8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_serializer.md
DAC_SERIALIZER -- requirements
Module: dac_serializer

Interface
REQ-001 Parameter Width, default 25: bit width of the filter sample on datoIn.
REQ-002 Parameter DacBits, default 12: DAC data width.
REQ-003 Parameter Shift, default 10: LSBs of datoIn discarded before saturation to DacBits.
REQ-004 Parameter ClkDiv, default 2: clk cycles per sclk half-period, minimum 1.
REQ-005 One clock, clk; reset is synchronous and active-low (reset low clears the block on the next rising clk edge).
REQ-006 clk  input  1  system clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous active-low reset.
REQ-008 enable  input  1  one-cycle sample strobe (44.1 kHz rate) qualifying datoIn.
REQ-009 datoIn  input  Width  two's-complement filter output sample.
REQ-010 sclk  output  1  serial clock to the DAC; idles high.
REQ-011 sync_n  output  1  DAC frame select; low during a frame.
REQ-012 dout  output  1  serial data, MSB first.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse at the end of each frame.
REQ-015 overrun  output  1  sticky flag: enable arrived while busy.

Function
REQ-016 FSM states: IDLE, LOAD, SHIFT, GAP; every encoding not listed returns to IDLE.
REQ-017 IDLE with enable=1: capture datoIn, go to LOAD next cycle; enable=0: stay in IDLE.
REQ-018 LOAD, exactly one cycle: form the 16-bit frame into the shift register; go to SHIFT.
REQ-019 Conversion: v = datoIn >>> Shift (arithmetic); if v > 2^(DacBits-1)-1 then v = 2^(DacBits-1)-1; if v < -2^(DacBits-1) then v = -2^(DacBits-1); code = v with MSB inverted (offset binary).
REQ-020 Frame = (16-DacBits) zero control bits followed by the DacBits code, MSB first, 16 bits total.
REQ-021 SHIFT: sync_n=0; each bit = ClkDiv cycles sclk high, then ClkDiv cycles sclk low; dout changes only at the start of the high phase; the DAC samples on the sclk falling edge.
REQ-022 First bit on dout in the first SHIFT cycle; SHIFT lasts exactly 32*ClkDiv cycles; a 4-bit bit counter ends the state after bit 0.
REQ-023 GAP: sync_n=1, sclk=1, dout=0 for 2*ClkDiv cycles; done=1 in the last GAP cycle; next state IDLE.
REQ-024 Frame period enable->done = 2+34*ClkDiv cycles (70 at default); a new enable is accepted in the cycle after done.
REQ-025 enable while busy=1: ignored, captured data unchanged, overrun set to 1; cleared only by reset.
REQ-026 enable in the same cycle as done: ignored, overrun set (the block is still busy).
REQ-027 datoIn changes outside an accepted enable cycle: no effect on the frame in progress.
REQ-028 Idle outputs: sclk=1, sync_n=1, dout=0, busy=0, done=0.

Reset
REQ-029 reset=0 at a clk edge: state IDLE, sclk=1, sync_n=1, dout=0, busy=0, done=0, overrun=0, shift register and counters 0.
REQ-030 Reset mid-frame: frame aborted at that edge; sync_n high in the next cycle; no done pulse.
REQ-031 reset dominates enable in the same cycle.

Structure
REQ-032 Shared package holds the FSM state encoding, the frame length constant (16) and the control-bit width (16-DacBits).
REQ-033 One sub-module, sat_offset, implements the combinational shift/saturate/offset-binary conversion of REQ-019.
REQ-034 All outputs registered; no combinational path from enable or datoIn to any output.

Verification
REQ-035 Default parameters, datoIn=0 with enable -> frame bits 0x0800, done 70 cycles after enable, overrun=0.
REQ-036 datoIn=25'h0100000 (+1048576, v=1024 > 2047? no: v=1024) -> code 0xC00; datoIn=25'h0FFFFFF -> saturated code 0xFFF; datoIn=25'h1000000 -> code 0x000.
REQ-037 datoIn=-1 (all ones) -> v=-1, code 0x7FF; bit-checker on sclk falling edges reads 16'h07FF.
REQ-038 Second enable 10 cycles after first -> first frame unchanged, overrun=1 held until reset; enable in the cycle after done -> new frame starts.
REQ-039 reset=0 in SHIFT bit 5 -> next cycle sync_n=1, sclk=1, busy=0, overrun=0, no done pulse.
REQ-040 ClkDiv=1: sclk period 2 cycles, enable->done 36 cycles, frame contents identical to the ClkDiv=2 run.
